// File: rtl/tcp_rx_ctrl_if.sv
// Header-event, payload-beat, close and ACK-handshake bundle between the RX parser, tcp_rx_ctrl and TX.
// Purely wires: no latency, no flow control of its own.
interface tcp_rx_ctrl_if #(
  parameter int DATA_W = 16
);
  localparam int LEN_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;

  logic              head_v_i;
  logic [31:0]       seq_i;
  logic [7:0]        flag_i;
  logic              pay_v_i;
  logic              valid_i;
  logic              start_i;
  logic              last_i;
  logic [LEN_W-1:0]  len_i;
  logic [DATA_W-1:0] data_i;
  logic              close_i;
  logic              valid_o;
  logic              start_o;
  logic              last_o;
  logic [LEN_W-1:0]  len_o;
  logic [DATA_W-1:0] data_o;
  logic              ack_req_o;
  logic              ack_rdy_i;
  logic [31:0]       ack_num_o;
  logic [1:0]        conn_o;
  logic [15:0]       drop_cnt_o;

  modport slave (
    input  head_v_i, seq_i, flag_i, pay_v_i,
    input  valid_i, start_i, last_i, len_i, data_i,
    input  close_i, ack_rdy_i,
    output valid_o, start_o, last_o, len_o, data_o,
    output ack_req_o, ack_num_o, conn_o, drop_cnt_o
  );

  modport master (
    output head_v_i, seq_i, flag_i, pay_v_i,
    output valid_i, start_i, last_i, len_i, data_i,
    output close_i, ack_rdy_i,
    input  valid_o, start_o, last_o, len_o, data_o,
    input  ack_req_o, ack_num_o, conn_o, drop_cnt_o
  );
endinterface

// File: rtl/tcp_rx_ctrl.sv
// Per-connection TCP RX controller: tracks conn state and rcv_nxt, gates in-order payload, schedules ACKs.
// Latency: payload 1 cycle registered. Backpressure: none on payload; ACK request held until ack_rdy_i.
module tcp_rx_ctrl #(
  parameter int DATA_W = 16
) (
  input logic          clk,
  input logic          nreset,
  tcp_rx_ctrl_if.slave rx
);
  localparam int LEN_W = (DATA_W > 8) ? $clog2(DATA_W / 8) : 1;
  localparam int SEQ_W = 32;

  typedef enum logic [1:0] {
    LISTEN     = 2'd0,
    SYN_RCVD   = 2'd1,
    ESTAB      = 2'd2,
    CLOSE_WAIT = 2'd3
  } conn_e;

  typedef enum logic [1:0] {
    SEG_IDLE = 2'd0,
    SEG_PASS = 2'd1,
    SEG_DROP = 2'd2
  } seg_e;

  seg_e              seg_q, seg_d;
  conn_e             conn_q, conn_d;
  logic [SEQ_W-1:0]  rcv_nxt_q, rcv_nxt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              ack_pend_q, ack_pend_d;
  logic              fin_pend_q, fin_pend_d;
  logic              valid_q, valid_d;
  logic              start_q, start_d;
  logic              last_q, last_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic             hdr_go, hdr_pass, beat_pass, ack_set, cnt_inc, seq_match;
  logic             f_fin, f_syn, f_rst, f_ack;
  logic [SEQ_W-1:0] beat_bytes;
  logic             unused_flags;

  assign f_fin        = rx.flag_i[0];
  assign f_syn        = rx.flag_i[1];
  assign f_rst        = rx.flag_i[2];
  assign f_ack        = rx.flag_i[4];
  assign unused_flags = ^{rx.flag_i[7:5], rx.flag_i[3]};

  assign hdr_go     = rx.head_v_i && (seg_q == SEG_IDLE);
  assign seq_match  = (rx.seq_i == rcv_nxt_q);
  assign beat_bytes = (rx.len_i == '0) ? 32'(DATA_W / 8) : 32'(rx.len_i);

  // Segment FSM: state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) seg_q <= SEG_IDLE;
    else         seg_q <= seg_d;
  end

  // Segment FSM: next state
  always_comb begin
    seg_d = seg_q;
    case (seg_q)
      SEG_IDLE: if (hdr_go && rx.pay_v_i) seg_d = hdr_pass ? SEG_PASS : SEG_DROP;
      SEG_PASS,
      SEG_DROP: if (rx.valid_i && rx.last_i) seg_d = SEG_IDLE;
      default:  seg_d = SEG_IDLE;
    endcase
  end

  // Segment FSM: outputs (payload gating into the output register stage)
  always_comb begin
    beat_pass = (seg_q == SEG_PASS) && rx.valid_i;
    valid_d   = beat_pass;
    start_d   = beat_pass && rx.start_i;
    last_d    = beat_pass && rx.last_i;
    len_d     = beat_pass ? rx.len_i  : len_q;
    data_d    = beat_pass ? rx.data_i : data_q;
  end

  // Connection state, rcv_nxt and ACK / drop bookkeeping
  always_comb begin
    conn_d     = conn_q;
    rcv_nxt_d  = rcv_nxt_q;
    fin_pend_d = fin_pend_q;
    hdr_pass   = 1'b0;
    ack_set    = 1'b0;
    cnt_inc    = 1'b0;

    if (hdr_go) begin
      if (f_rst) begin
        conn_d = LISTEN;
      end else begin
        case (conn_q)
          LISTEN: begin
            if (f_syn && !f_ack) begin
              rcv_nxt_d = rx.seq_i + 32'd1;
              ack_set   = 1'b1;
              conn_d    = SYN_RCVD;
            end else begin
              cnt_inc = 1'b1;
            end
          end
          SYN_RCVD, ESTAB: begin
            if (seq_match && (conn_q == ESTAB || f_ack)) begin
              conn_d   = ESTAB;
              hdr_pass = 1'b1;
              // A FIN with payload is consumed only after the segment's last beat.
              if (f_fin) begin
                if (rx.pay_v_i) begin
                  fin_pend_d = 1'b1;
                end else begin
                  rcv_nxt_d = rcv_nxt_q + 32'd1;
                  conn_d    = CLOSE_WAIT;
                  ack_set   = 1'b1;
                end
              end
            end else begin
              cnt_inc = 1'b1;
              ack_set = (conn_q == ESTAB);
            end
          end
          default: cnt_inc = 1'b1;
        endcase
      end
    end else if (rx.head_v_i) begin
      cnt_inc = 1'b1;
    end

    if (beat_pass) begin
      rcv_nxt_d = rcv_nxt_q + beat_bytes + {31'd0, rx.last_i && fin_pend_q};
      if (rx.last_i) begin
        ack_set    = 1'b1;
        fin_pend_d = 1'b0;
        if (fin_pend_q) conn_d = CLOSE_WAIT;
      end
    end

    if (rx.close_i && conn_q == CLOSE_WAIT) conn_d = LISTEN;

    ack_pend_d = ack_set || (ack_pend_q && !rx.ack_rdy_i);
    drop_cnt_d = (cnt_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      conn_q     <= LISTEN;
      rcv_nxt_q  <= '0;
      drop_cnt_q <= '0;
      ack_pend_q <= 1'b0;
      fin_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      last_q     <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
    end else begin
      conn_q     <= conn_d;
      rcv_nxt_q  <= rcv_nxt_d;
      drop_cnt_q <= drop_cnt_d;
      ack_pend_q <= ack_pend_d;
      fin_pend_q <= fin_pend_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      last_q     <= last_d;
      len_q      <= len_d;
      data_q     <= data_d;
    end
  end

  assign rx.valid_o    = valid_q;
  assign rx.start_o    = start_q;
  assign rx.last_o     = last_q;
  assign rx.len_o      = len_q;
  assign rx.data_o     = data_q;
  assign rx.ack_req_o  = ack_pend_q;
  assign rx.ack_num_o  = rcv_nxt_q;
  assign rx.conn_o     = conn_q;
  assign rx.drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_tcp_rx_ctrl.sv
// Self-checking bench for tcp_rx_ctrl: segment-level reference model, per-cycle compare, directed + random stimulus.
module tb_tcp_rx_ctrl;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 1;
  localparam logic [7:0] F_FIN = 8'h01, F_SYN = 8'h02, F_RST = 8'h04, F_PSH = 8'h08, F_ACK = 8'h10;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  tcp_rx_ctrl_if #(.DATA_W(DATA_W)) rx ();
  tcp_rx_ctrl #(.DATA_W(DATA_W)) dut (.clk(clk), .nreset(nreset), .rx(rx));

  int checks = 0;
  int failures = 0;

  // Reference model: committed (m_*) values and values for the cycle being driven (n_*)
  logic [1:0]       m_conn, n_conn;
  logic [31:0]      m_rcv, n_rcv;
  logic [15:0]      m_drop, n_drop;
  logic             m_pend, n_set;
  logic             e_vld, n_vld, e_start, n_start, e_last, n_last;
  logic [LEN_W-1:0] e_len, n_len;
  logic [15:0]      e_dat, n_dat;
  bit               seg_busy, seg_pass, seg_fin;
  bit               chk_en;
  int               rdy_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic idle_inputs();
    rx.head_v_i = 1'b0; rx.pay_v_i = 1'b0; rx.valid_i = 1'b0;
    rx.start_i = 1'b0;  rx.last_i = 1'b0;  rx.close_i = 1'b0;
    rx.seq_i = $urandom; rx.flag_i = 8'($urandom);
    rx.len_i = LEN_W'($urandom); rx.data_i = 16'($urandom);
    case (rdy_mode)
      0:       rx.ack_rdy_i = 1'($urandom_range(0, 1));
      1:       rx.ack_rdy_i = 1'b0;
      default: rx.ack_rdy_i = 1'b1;
    endcase
    n_conn = m_conn; n_rcv = m_rcv; n_drop = m_drop; n_set = 1'b0;
    n_vld = 1'b0; n_start = 1'b0; n_last = 1'b0; n_len = '0; n_dat = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    m_pend  = n_set | (m_pend & ~rx.ack_rdy_i);
    m_conn  = n_conn; m_rcv = n_rcv; m_drop = n_drop;
    e_vld   = n_vld; e_start = n_start; e_last = n_last; e_len = n_len; e_dat = n_dat;
    #1;
    idle_inputs();
  endtask

  task automatic model_reset();
    m_conn = 2'd0; m_rcv = 32'd0; m_drop = 16'd0; m_pend = 1'b0;
    e_vld = 1'b0; e_start = 1'b0; e_last = 1'b0; e_len = '0; e_dat = '0;
    seg_busy = 1'b0; seg_pass = 1'b0; seg_fin = 1'b0;
  endtask

  task automatic head(input logic [31:0] seq, input logic [7:0] fl, input bit pay);
    bit pass;
    bit defer;
    pass = 1'b0;
    defer = 1'b0;
    rx.head_v_i = 1'b1; rx.seq_i = seq; rx.flag_i = fl; rx.pay_v_i = pay;
    if (seg_busy) begin
      n_drop = sat_inc(m_drop);
    end else begin
      if (fl[2]) begin
        n_conn = 2'd0;
      end else if (m_conn == 2'd0) begin
        if (fl[1] && !fl[4]) begin n_rcv = seq + 32'd1; n_set = 1'b1; n_conn = 2'd1; end
        else n_drop = sat_inc(m_drop);
      end else if ((m_conn == 2'd2 || (m_conn == 2'd1 && fl[4])) && seq == m_rcv) begin
        n_conn = 2'd2;
        pass = 1'b1;
        if (fl[0]) begin
          if (pay) defer = 1'b1;
          else begin n_rcv = m_rcv + 32'd1; n_conn = 2'd3; n_set = 1'b1; end
        end
      end else begin
        n_drop = sat_inc(m_drop);
        if (m_conn == 2'd2) n_set = 1'b1;
      end
      if (pay) begin seg_busy = 1'b1; seg_pass = pass; seg_fin = defer; end
    end
  endtask

  task automatic beat(input bit st, input bit ls, input logic [LEN_W-1:0] ln, input logic [15:0] d);
    rx.valid_i = 1'b1; rx.start_i = st; rx.last_i = ls; rx.len_i = ln; rx.data_i = d;
    if (seg_busy && seg_pass) begin
      n_vld = 1'b1; n_start = st; n_last = ls; n_len = ln; n_dat = d;
      n_rcv = m_rcv + ((ln == 0) ? 32'(DATA_W / 8) : 32'(ln));
      if (ls) begin
        n_set = 1'b1;
        if (seg_fin) begin n_rcv = n_rcv + 32'd1; n_conn = 2'd3; end
      end
    end
    if (ls) seg_busy = 1'b0;
  endtask

  task automatic close_pulse();
    rx.close_i = 1'b1;
    if (m_conn == 2'd3) n_conn = 2'd0;
  endtask

  task automatic accept();
    rx.ack_rdy_i = 1'b1;
    tick();
  endtask

  task automatic send_seg(input logic [31:0] seq, input logic [7:0] fl, input bit pay, input int nb);
    head(seq, fl, pay);
    tick();
    if (pay) begin
      for (int b = 0; b < nb; b++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          if ($urandom_range(0, 7) == 0) head($urandom, F_ACK, 1'b1);
          tick();
        end
        beat(b == 0, b == nb - 1, LEN_W'($urandom), 16'($urandom));
        tick();
      end
    end
  endtask

  task automatic reset_zero_check(input string tag);
    chk({tag, "_valid"}, rx.valid_o, 0);
    chk({tag, "_start"}, rx.start_o, 0);
    chk({tag, "_last"},  rx.last_o, 0);
    chk({tag, "_len"},   rx.len_o, 0);
    chk({tag, "_data"},  rx.data_o, 0);
    chk({tag, "_req"},   rx.ack_req_o, 0);
    chk({tag, "_num"},   rx.ack_num_o, 0);
    chk({tag, "_conn"},  rx.conn_o, 0);
    chk({tag, "_drop"},  rx.drop_cnt_o, 0);
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_o", rx.valid_o, e_vld);
      if (e_vld) begin
        chk("start_o", rx.start_o, e_start);
        chk("last_o",  rx.last_o,  e_last);
        chk("len_o",   rx.len_o,   e_len);
        chk("data_o",  rx.data_o,  e_dat);
      end
      chk("conn_o",     rx.conn_o,     m_conn);
      chk("ack_num_o",  rx.ack_num_o,  m_rcv);
      chk("ack_req_o",  rx.ack_req_o,  m_pend);
      chk("drop_cnt_o", rx.drop_cnt_o, m_drop);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    logic [31:0] acc_num;
    chk_en = 1'b0;
    rdy_mode = 1;
    model_reset();
    idle_inputs();
    #2;
    reset_zero_check("por");
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    chk_en = 1'b1;

    // Three-way handshake
    head(32'h1000, F_SYN, 1'b0); tick();
    chk("hs_conn", rx.conn_o, 1);
    chk("hs_req", rx.ack_req_o, 1);
    chk("hs_num", rx.ack_num_o, 32'h1001);
    accept();
    chk("hs_req_clr", rx.ack_req_o, 0);
    head(32'h1001, F_ACK, 1'b0); tick();
    chk("hs_estab", rx.conn_o, 2);

    // In-order data, lens 0,0,1
    head(32'h1001, F_ACK | F_PSH, 1'b1); tick();
    beat(1'b1, 1'b0, 1'b0, 16'hA0A1); tick();
    chk("io_v1", rx.valid_o, 1); chk("io_d1", rx.data_o, 16'hA0A1); chk("io_s1", rx.start_o, 1);
    beat(1'b0, 1'b0, 1'b0, 16'hB0B1); tick();
    chk("io_v2", rx.valid_o, 1); chk("io_d2", rx.data_o, 16'hB0B1);
    beat(1'b0, 1'b1, 1'b1, 16'hC0C1); tick();
    chk("io_v3", rx.valid_o, 1); chk("io_l3", rx.last_o, 1); chk("io_len3", rx.len_o, 1);
    tick();
    chk("io_v_end", rx.valid_o, 0);
    chk("io_num", rx.ack_num_o, 32'h1006);
    chk("io_req", rx.ack_req_o, 1);
    accept();

    // Out-of-order segment
    head(32'h2000, F_ACK, 1'b1); tick();
    beat(1'b1, 1'b0, 1'b0, 16'h1111); tick();
    chk("oo_v1", rx.valid_o, 0);
    beat(1'b0, 1'b1, 1'b0, 16'h2222); tick();
    chk("oo_v2", rx.valid_o, 0);
    chk("oo_drop", rx.drop_cnt_o, 1);
    chk("oo_req", rx.ack_req_o, 1);
    chk("oo_num", rx.ack_num_o, 32'h1006);
    accept();

    // Sequence wrap with FIN, then application close
    head(32'h0, F_RST, 1'b0); tick();
    chk("rst_conn", rx.conn_o, 0);
    head(32'hFFFF_FFFD, F_SYN, 1'b0); tick();
    accept();
    head(32'hFFFF_FFFE, F_ACK, 1'b0); tick();
    chk("wr_estab", rx.conn_o, 2);
    head(32'hFFFF_FFFE, F_ACK | F_FIN, 1'b1); tick();
    beat(1'b1, 1'b1, 1'b0, 16'h5A5A); tick();
    chk("wr_num", rx.ack_num_o, 32'h0000_0001);
    chk("wr_conn", rx.conn_o, 3);
    chk("wr_req", rx.ack_req_o, 1);
    accept();
    close_pulse(); tick();
    chk("cl_conn", rx.conn_o, 0);

    // Coalescing: two pend events, one accept with the latest number
    head(32'h500, F_SYN, 1'b0); tick();
    head(32'h501, F_ACK, 1'b0); tick();
    head(32'h501, F_ACK | F_PSH, 1'b1); tick();
    beat(1'b1, 1'b1, 1'b1, 16'h0F0F); tick();
    acc = 0;
    acc_num = 32'd0;
    for (int k = 0; k < 3; k++) begin
      rx.ack_rdy_i = 1'b1;
      if (rx.ack_req_o) begin acc++; acc_num = rx.ack_num_o; end
      tick();
    end
    chk("co_accepts", acc, 1);
    chk("co_num", acc_num, 32'h502);
    // A set coincident with an accept keeps the request up
    head(32'h9999, F_ACK, 1'b0); tick();
    rx.ack_rdy_i = 1'b1;
    head(32'h9998, F_ACK, 1'b0); tick();
    chk("co_repend", rx.ack_req_o, 1);
    accept();
    chk("co_clr", rx.ack_req_o, 0);

    // Randomized traffic
    rdy_mode = 0;
    for (int i = 0; i < 200; i++) begin
      logic [31:0] sq;
      logic [7:0]  fl;
      bit          pay;
      int          nb;
      pay = ($urandom_range(0, 3) != 0);
      nb  = $urandom_range(1, 4);
      sq  = ($urandom_range(0, 3) != 0) ? m_rcv : $urandom;
      fl  = F_ACK | (($urandom_range(0, 1) != 0) ? F_PSH : 8'h00);
      if (m_conn == 2'd0) begin
        fl = ($urandom_range(0, 3) != 0) ? F_SYN : 8'($urandom);
        if ($urandom_range(0, 3) == 0) sq = 32'hFFFF_FFF0 + $urandom_range(0, 15);
      end else if (m_conn == 2'd2) begin
        if ($urandom_range(0, 7) == 0) fl = fl | F_FIN;
        if ($urandom_range(0, 19) == 0) fl = F_RST;
      end else if (m_conn == 2'd3 && $urandom_range(0, 1) != 0) begin
        close_pulse();
        tick();
        continue;
      end
      send_seg(sq, fl, pay, nb);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of a passing segment
    rdy_mode = 1;
    idle_inputs();
    head(32'h0, F_RST, 1'b0); tick();
    head(32'h7000, F_SYN, 1'b0); tick();
    head(32'h7001, F_ACK, 1'b0); tick();
    head(32'h7001, F_ACK, 1'b1); tick();
    beat(1'b1, 1'b0, 1'b0, 16'h1234); tick();
    chk("rs_pre_v", rx.valid_o, 1);
    #1;
    chk_en = 1'b0;
    nreset = 1'b0;
    #1;
    reset_zero_check("rs_mid");
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    chk_en = 1'b1;
    beat(1'b1, 1'b0, 1'b0, 16'hDEAD); tick();
    chk("rs_stray1", rx.valid_o, 0);
    beat(1'b0, 1'b1, 1'b1, 16'hBEEF); tick();
    chk("rs_stray2", rx.valid_o, 0);
    beat(1'b1, 1'b1, 1'b0, 16'hCAFE); tick();
    chk("rs_stray3", rx.valid_o, 0);
    chk("rs_conn", rx.conn_o, 0);

    // drop_cnt saturation: headers arriving while a segment is in flight
    rdy_mode = 0;
    head(32'h0, F_ACK, 1'b1); tick();
    for (int k = 0; k < 65540; k++) begin
      head($urandom, F_ACK, 1'b1);
      tick();
    end
    beat(1'b1, 1'b1, 1'b0, 16'h0); tick();
    chk("sat_cnt", rx.drop_cnt_o, 16'hFFFF);
    head(32'h0, F_ACK, 1'b0); tick();
    chk("sat_hold", rx.drop_cnt_o, 16'hFFFF);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tcp_rx_ctrl.md
Name: tcp_rx_ctrl

Overview:
Per-connection receive controller behind the TCP RX header parser. It consumes parsed header events (sequence number, flags) and the payload stream, and tracks the connection state and the expected sequence number (rcv_nxt). It gates in-order payload through to the application, discards out-of-order or unexpected payload, and schedules ACK requests to the TCP TX path over a valid/ready handshake.

Parameters:
DATA_W, 16, payload beat width in bits; multiple of 8.
LEN_W, $clog2(DATA_W/8), width of the per-beat byte-count field (derived, not overridable).
SEQ_W, 32, sequence number width (fixed).
FLAG_W, 8, TCP flag byte width (fixed).

Ports:
clk  in  1  clock.
nreset  in  1  asynchronous active-low reset.
head_v_i  in  1  one-cycle pulse: seq_i, flag_i, pay_v_i valid.
seq_i  in  SEQ_W  segment sequence number.
flag_i  in  FLAG_W  flags; bit0 FIN, 1 SYN, 2 RST, 3 PSH, 4 ACK.
pay_v_i  in  1  segment carries payload; sampled with head_v_i.
valid_i  in  1  payload beat valid.
start_i  in  1  first payload beat.
last_i  in  1  last payload beat.
len_i  in  LEN_W  bytes in beat; 0 = DATA_W/8 bytes.
data_i  in  DATA_W  payload.
close_i  in  1  application close pulse.
valid_o  out  1  in-order payload beat.
start_o  out  1  first beat.
last_o  out  1  last beat.
len_o  out  LEN_W  byte count, same encoding as len_i.
data_o  out  DATA_W  payload.
ack_req_o  out  1  ACK request to TX.
ack_rdy_i  in  1  TX accepts the ACK.
ack_num_o  out  SEQ_W  acknowledgment number (= rcv_nxt).
conn_o  out  2  connection state: 0 LISTEN, 1 SYN_RCVD, 2 ESTAB, 3 CLOSE_WAIT.
drop_cnt_o  out  16  dropped-segment count; saturates at 16'hFFFF.

Behaviour:
- Reset (async, nreset low): all outputs 0; conn LISTEN; rcv_nxt 0; segment FSM SEG_IDLE; ACK not pending. Reset mid-segment aborts the segment with no residual output.
- Ordering: head_v_i precedes the segment's start_i by at least 1 cycle. Beats occur only between start_i and last_i. A one-beat segment has start_i and last_i set in the same cycle.
- Header decision, evaluated on head_v_i in SEG_IDLE. Let match = (seq_i == rcv_nxt).
  - RST in any state: conn goes to LISTEN; payload is dropped; no ACK.
  - LISTEN: SYN & ~ACK sets rcv_nxt = seq_i+1, pends ACK, moves to SYN_RCVD. Anything else drops and increments drop_cnt.
  - SYN_RCVD: ACK & match moves to ESTAB, then handled as ESTAB in the same cycle. Otherwise drop.
  - ESTAB & match: payload passes. FIN adds 1 to rcv_nxt after payload, moves to CLOSE_WAIT and pends ACK.
  - ESTAB & ~match: drop, drop_cnt+1, pend a duplicate ACK.
  - CLOSE_WAIT: drop; close_i moves conn to LISTEN.
- Segment FSM: SEG_IDLE goes to SEG_PASS or SEG_DROP on head_v_i & pay_v_i. It returns to SEG_IDLE on valid_i & last_i. A header-only segment stays in SEG_IDLE.
- head_v_i while not in SEG_IDLE is ignored and counted in drop_cnt.
- Payload path, 1-cycle registered latency: valid_o = valid_i in SEG_PASS. start_o, last_o, len_o, data_o are registered with it. Output data is don't-care when valid_o=0.
- Each passed beat adds bytes(len_i) to rcv_nxt, modulo 2^32. Wrap 32'hFFFFFFFF+1 = 0.
- ACK pend happens on the last passed beat, on the events above, and on a FIN (applied after that beat's increment).
- ACK handshake:
  - ack_req_o stays high while pending; ack_num_o = rcv_nxt live.
  - pending_next = set | (pending & ~ack_rdy_i). A set in the same cycle as the accept re-pends.
  - Multiple sets before accept coalesce into one request.
- drop_cnt saturates and never wraps.

Test Plan:
- Handshake: LISTEN, head seq=0x1000 flags=SYN, then ack_rdy_i=1 -> conn=1, ack_req_o=1 with ack_num_o=0x1001, cleared the cycle after the accept. Then head seq=0x1001 flags=ACK -> conn=2.
- In-order data: ESTAB rcv_nxt=0x1001; head seq=0x1001, 3 beats with len 0,0,1 -> valid_o for 3 cycles, each 1 cycle after its input. rcv_nxt=0x1006. ACK with 0x1006 pends after the last beat.
- Out-of-order: head seq=0x2000 with rcv_nxt=0x1006, 2 beats -> valid_o stays 0, drop_cnt=1, ACK with 0x1006 pends.
- Wrap and FIN: rcv_nxt=0xFFFFFFFE; head match, FIN, one beat len=0 (2 bytes) -> rcv_nxt=0x00000001, conn=3, ack_num_o=0x00000001. Then close_i -> conn=0.
- Coalescing: hold ack_rdy_i=0 across two ACK-pending events -> exactly one accept with the latest rcv_nxt. A set coincident with ack_rdy_i=1 -> ack_req_o stays high the next cycle.
- Reset mid-segment: drop nreset during a SEG_PASS beat -> all outputs 0 immediately. After release, stray beats without a head -> valid_o=0.
